bram_dual_port: RTL and testbench

BRAM_DUAL_PORT -- requirements
Module: bram_dual_port

---
 rtl/bram_dual_port.sv | 146 ++++++++++++++
 tb/tb_bram_dual_port.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_dual_port.sv
// ============================================================================
// Module   : bram_dual_port
// Purpose  : True dual-port block RAM with per-byte write enables, selectable
//            same-port write behaviour, optional second output register and
//            a write-collision flag.
// Revision : 1.1
// ============================================================================
`default_nettype none

module bram_dual_port #(
    parameter int    RAM_WIDTH       = 32,
    parameter int    RAM_ADDR_BITS   = 9,
    parameter int    READ_LATENCY    = 1,
    parameter int    WRITE_MODE      = 0,
    parameter string DATA_FILE       = "",
    parameter int    INIT_START_ADDR = 0,
    parameter int    INIT_END_ADDR   = 10
) (
    input  logic                     clock,
    input  logic                     reset_n,

    input  logic                     a_enable,
    input  logic [RAM_WIDTH/8-1:0]   a_byte_we,
    input  logic [RAM_ADDR_BITS-1:0] a_address,
    input  logic [RAM_WIDTH-1:0]     a_in_data,
    output logic [RAM_WIDTH-1:0]     a_out_data,
    output logic                     a_out_valid,

    input  logic                     b_enable,
    input  logic [RAM_WIDTH/8-1:0]   b_byte_we,
    input  logic [RAM_ADDR_BITS-1:0] b_address,
    input  logic [RAM_WIDTH-1:0]     b_in_data,
    output logic [RAM_WIDTH-1:0]     b_out_data,
    output logic                     b_out_valid,

    output logic                     collision
);

    localparam int C_NUM_BYTES = RAM_WIDTH / 8;
    localparam int C_DEPTH     = 2 ** RAM_ADDR_BITS;

    // Storage array; deliberately without reset so it maps onto block RAM.
    logic [RAM_WIDTH-1:0] r_mem [0:C_DEPTH-1];

    logic                 w_a_is_write;
    logic                 w_b_is_write;
    logic                 w_overlap;
    logic [RAM_WIDTH-1:0] w_a_merged;
    logic [RAM_WIDTH-1:0] w_b_merged;

    // First output stage registers, one per port.
    logic [RAM_WIDTH-1:0] r_a_s1_data;
    logic                 r_a_s1_valid;
    logic [RAM_WIDTH-1:0] r_b_s1_data;
    logic                 r_b_s1_valid;
    logic                 r_collision;

    assign w_a_is_write = |a_byte_we;
    assign w_b_is_write = |b_byte_we;

    // Both ports write at least one common byte lane of the same word.
    assign w_overlap = a_enable && b_enable && (a_address == b_address) &&
                       (|(a_byte_we & b_byte_we));

    // Post-write view of the addressed word as seen by its own port only.
    always_comb begin
        w_a_merged = r_mem[a_address];
        w_b_merged = r_mem[b_address];
        for (int i = 0; i < C_NUM_BYTES; i++) begin
            if (a_byte_we[i]) w_a_merged[8*i +: 8] = a_in_data[8*i +: 8];
            if (b_byte_we[i]) w_b_merged[8*i +: 8] = b_in_data[8*i +: 8];
        end
    end

    // Byte-lane writes; port A is applied last so it wins on shared lanes.
    // Writes are suppressed while reset is held so a word is never torn.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            for (int i = 0; i < C_NUM_BYTES; i++) begin
                if (b_enable && b_byte_we[i]) r_mem[b_address][8*i +: 8] <= b_in_data[8*i +: 8];
                if (a_enable && a_byte_we[i]) r_mem[a_address][8*i +: 8] <= a_in_data[8*i +: 8];
            end
        end
    end

    // First read stage: pick old/merged data per write mode, flag collisions.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a_s1_data  <= '0;
            r_a_s1_valid <= 1'b0;
            r_b_s1_data  <= '0;
            r_b_s1_valid <= 1'b0;
            r_collision  <= 1'b0;
        end else begin
            r_a_s1_valid <= 1'b0;
            r_b_s1_valid <= 1'b0;
            r_collision  <= w_overlap;
            // No-change mode leaves the output untouched on any writing access.
            if (a_enable && !(WRITE_MODE == 2 && w_a_is_write)) begin
                r_a_s1_valid <= 1'b1;
                r_a_s1_data  <= (WRITE_MODE == 1) ? w_a_merged : r_mem[a_address];
            end
            if (b_enable && !(WRITE_MODE == 2 && w_b_is_write)) begin
                r_b_s1_valid <= 1'b1;
                r_b_s1_data  <= (WRITE_MODE == 1) ? w_b_merged : r_mem[b_address];
            end
        end
    end

    assign collision = r_collision;

    if (READ_LATENCY == 2) begin : g_lat2
        logic [RAM_WIDTH-1:0] r_a_s2_data;
        logic                 r_a_s2_valid;
        logic [RAM_WIDTH-1:0] r_b_s2_data;
        logic                 r_b_s2_valid;

        // Second output register; data only advances with a valid beat.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_a_s2_data  <= '0;
                r_a_s2_valid <= 1'b0;
                r_b_s2_data  <= '0;
                r_b_s2_valid <= 1'b0;
            end else begin
                r_a_s2_valid <= r_a_s1_valid;
                r_b_s2_valid <= r_b_s1_valid;
                if (r_a_s1_valid) r_a_s2_data <= r_a_s1_data;
                if (r_b_s1_valid) r_b_s2_data <= r_b_s1_data;
            end
        end

        assign a_out_data  = r_a_s2_data;
        assign a_out_valid = r_a_s2_valid;
        assign b_out_data  = r_b_s2_data;
        assign b_out_valid = r_b_s2_valid;
    end else begin : g_lat1
        assign a_out_data  = r_a_s1_data;
        assign a_out_valid = r_a_s1_valid;
        assign b_out_data  = r_b_s1_data;
        assign b_out_valid = r_b_s1_valid;
    end

endmodule

`default_nettype wire

// File: tb/tb_bram_dual_port.sv
// ============================================================================
// Module   : tb_bram_dual_port
// Purpose  : Directed bench for bram_dual_port. Four instances share the same
//            stimulus: [0] latency 1 read-first, [1] latency 1 write-first,
//            [2] latency 2 read-first, [3] latency 1 no-change.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_dual_port;

  logic        clock;
  logic        reset_n;
  logic        a_enable;
  logic [3:0]  a_byte_we;
  logic [3:0]  a_address;
  logic [31:0] a_in_data;
  logic        b_enable;
  logic [3:0]  b_byte_we;
  logic [3:0]  b_address;
  logic [31:0] b_in_data;

  logic [31:0] a_out [4];
  logic        a_val [4];
  logic [31:0] b_out [4];
  logic        b_val [4];
  logic        coll  [4];

  int checks   = 0;
  int failures = 0;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    bram_dual_port #(
      .RAM_WIDTH     (32),
      .RAM_ADDR_BITS (4),
      .READ_LATENCY  ((k == 2) ? 2 : 1),
      .WRITE_MODE    ((k == 1) ? 1 : ((k == 3) ? 2 : 0))
    ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .a_enable    (a_enable),
      .a_byte_we   (a_byte_we),
      .a_address   (a_address),
      .a_in_data   (a_in_data),
      .a_out_data  (a_out[k]),
      .a_out_valid (a_val[k]),
      .b_enable    (b_enable),
      .b_byte_we   (b_byte_we),
      .b_address   (b_address),
      .b_in_data   (b_in_data),
      .b_out_data  (b_out[k]),
      .b_out_valid (b_val[k]),
      .collision   (coll[k])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_a(input logic en, input logic [3:0] we, input logic [3:0] addr,
                       input logic [31:0] data);
    a_enable = en; a_byte_we = we; a_address = addr; a_in_data = data;
  endtask

  task automatic set_b(input logic en, input logic [3:0] we, input logic [3:0] addr,
                       input logic [31:0] data);
    b_enable = en; b_byte_we = we; b_address = addr; b_in_data = data;
  endtask

  task automatic idle();
    set_a(1'b0, 4'h0, 4'h0, 32'h0);
    set_b(1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    #2;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_a_out[%0d]", k), a_out[k], 32'h0);
      check($sformatf("rst_a_val[%0d]", k), {31'h0, a_val[k]}, 32'h0);
      check($sformatf("rst_b_out[%0d]", k), b_out[k], 32'h0);
      check($sformatf("rst_coll[%0d]", k), {31'h0, coll[k]}, 32'h0);
    end
    @(negedge clock);
    reset_n = 1'b1;

    // Same-port write then read at address 5.
    set_a(1'b1, 4'hF, 4'd5, 32'h01010101); tick();
    set_a(1'b1, 4'hF, 4'd5, 32'hDEADBEEF); tick();
    check("rf_old_word",  a_out[0], 32'h01010101);
    check("rf_valid",     {31'h0, a_val[0]}, 32'h1);
    check("wf_new_word",  a_out[1], 32'hDEADBEEF);
    check("nc_valid_low", {31'h0, a_val[3]}, 32'h0);
    check("nc_data_held", a_out[3], 32'h0);
    set_a(1'b1, 4'h0, 4'd5, 32'h0); tick();
    check("rd_after_wr",  a_out[0], 32'hDEADBEEF);
    check("nc_read",      a_out[3], 32'hDEADBEEF);
    check("nc_read_val",  {31'h0, a_val[3]}, 32'h1);
    idle(); tick();
    check("idle_val_low", {31'h0, a_val[0]}, 32'h0);
    check("idle_held",    a_out[0], 32'hDEADBEEF);
    check("lat2_rd",      a_out[2], 32'hDEADBEEF);
    check("lat2_val",     {31'h0, a_val[2]}, 32'h1);

    // Byte-enable merge at address 7.
    set_a(1'b1, 4'hF, 4'd7, 32'h11223344); tick();
    set_a(1'b1, 4'b0101, 4'd7, 32'hAABBCCDD); tick();
    check("wf_merge",     a_out[1], 32'h11BB33DD);
    check("rf_premerge",  a_out[0], 32'h11223344);
    set_a(1'b1, 4'h0, 4'd7, 32'h0); tick();
    check("merge_stored", a_out[0], 32'h11BB33DD);

    // Write collisions at address 3.
    set_a(1'b1, 4'hF, 4'd3, 32'h000000FF);
    set_b(1'b1, 4'hF, 4'd3, 32'hFFFFFF00); tick();
    check("coll_hi",      {31'h0, coll[0]}, 32'h1);
    check("coll_hi_lat2", {31'h0, coll[2]}, 32'h1);
    idle(); tick();
    check("coll_lo",      {31'h0, coll[0]}, 32'h0);
    set_a(1'b1, 4'h0, 4'd3, 32'h0); tick();
    check("coll_a_wins",  a_out[0], 32'h000000FF);
    set_a(1'b1, 4'b0001, 4'd3, 32'h000000AA);
    set_b(1'b1, 4'b0011, 4'd3, 32'h0000BBCC); tick();
    check("coll_partial", {31'h0, coll[0]}, 32'h1);
    set_a(1'b1, 4'b0001, 4'd3, 32'h00000011);
    set_b(1'b1, 4'b0010, 4'd3, 32'h00002200); tick();
    check("no_overlap",   {31'h0, coll[0]}, 32'h0);
    set_a(1'b0, 4'h0, 4'd0, 32'h0);
    set_b(1'b1, 4'h0, 4'd3, 32'h0); tick();
    check("lane_mix",     b_out[0], 32'h00002211);

    // Cross-port read during a write at address 9.
    set_a(1'b1, 4'hF, 4'd9, 32'h0);
    set_b(1'b0, 4'h0, 4'd0, 32'h0); tick();
    set_a(1'b1, 4'hF, 4'd9, 32'h12345678);
    set_b(1'b1, 4'h0, 4'd9, 32'h0); tick();
    check("xport_old_rf", b_out[0], 32'h0);
    check("xport_val",    {31'h0, b_val[0]}, 32'h1);
    check("xport_old_wf", b_out[1], 32'h0);
    set_a(1'b0, 4'h0, 4'd0, 32'h0); tick();
    check("xport_new",    b_out[0], 32'h12345678);

    // Two-stage pipeline with back-to-back reads, plus the top address.
    set_b(1'b0, 4'h0, 4'd0, 32'h0);
    set_a(1'b1, 4'hF, 4'd0,  32'h000000A0); tick();
    set_a(1'b1, 4'hF, 4'd1,  32'h000000A1); tick();
    set_a(1'b1, 4'hF, 4'd2,  32'h000000A2); tick();
    set_a(1'b1, 4'hF, 4'd15, 32'hF00D000F); tick();
    idle(); tick(); tick();
    set_a(1'b1, 4'h0, 4'd0, 32'h0); tick();
    check("p_e1_val",     {31'h0, a_val[2]}, 32'h0);
    check("p_l1_e1",      a_out[0], 32'h000000A0);
    set_a(1'b1, 4'h0, 4'd1, 32'h0); tick();
    check("p_e2",         a_out[2], 32'h000000A0);
    check("p_e2_val",     {31'h0, a_val[2]}, 32'h1);
    set_a(1'b1, 4'h0, 4'd2, 32'h0); tick();
    check("p_e3",         a_out[2], 32'h000000A1);
    idle(); tick();
    check("p_e4",         a_out[2], 32'h000000A2);
    check("p_e4_val",     {31'h0, a_val[2]}, 32'h1);
    tick();
    check("p_e5_val",     {31'h0, a_val[2]}, 32'h0);
    set_a(1'b1, 4'h0, 4'd15, 32'h0); tick();
    check("addr_top",     a_out[0], 32'hF00D000F);
    set_a(1'b1, 4'h0, 4'd0, 32'h0); tick();
    check("addr_zero",    a_out[0], 32'h000000A0);

    // Reset while a latency-2 read is in flight.
    idle(); tick(); tick();
    set_a(1'b1, 4'h0, 4'd15, 32'h0); tick();
    reset_n = 1'b0;
    idle();
    #1;
    check("rst_mid_out",  a_out[2], 32'h0);
    check("rst_mid_val",  {31'h0, a_val[2]}, 32'h0);
    check("rst_mid_l1",   a_out[0], 32'h0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      check($sformatf("rst_no_val%0d", n), {31'h0, a_val[2]}, 32'h0);
    end
    set_a(1'b1, 4'h0, 4'd15, 32'h0); tick();
    check("mem_retained", a_out[0], 32'hF00D000F);
    idle(); tick();
    check("mem_ret_lat2", a_out[2], 32'hF00D000F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
